// File: rtl/mult_unit_if.sv
// mult_unit_if: request/response bundle between a decoder stage and the multiplier
interface mult_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            signed_a;
    logic            signed_b;
    logic            half;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, a, b, signed_a, signed_b, half, flush, input busy, done, result);
    modport slave (input start, a, b, signed_a, signed_b, half, flush, output busy, done, result);
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add 32x32 multiplier with signed/unsigned operands and high/low half select
module mult_unit #(parameter int XLEN = 32) (
    input logic       CLK,
    input logic       nRST,
    mult_unit_if.slave m
);
    localparam int W2 = 2 * XLEN;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    logic [1:0]      state_q, state_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            half_q, half_d;
    logic            done_q, done_d;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_neg = m.signed_a & m.a[XLEN-1];
    assign b_neg = m.signed_b & m.b[XLEN-1];
    assign a_mag = a_neg ? -m.a : m.a;
    assign b_mag = b_neg ? -m.b : m.b;
    assign m.busy   = state_q != IDLE;
    assign m.done   = done_q;
    assign m.result = result_q;
    // next-state: accept, shift-add steps, sign fix-up, result capture; flush aborts any active op
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        half_d   = half_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (m.start && !m.flush) begin
                mcand_d  = {{XLEN{1'b0}}, a_mag};
                mplier_d = b_mag;
                neg_d    = a_neg ^ b_neg;
                half_d   = m.half;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = CALC;
            end
            CALC: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                state_d  = cnt_q == 6'd31 ? FIX : CALC;
            end
            FIX: begin
                acc_d   = neg_q ? -acc_q : acc_q;
                state_d = DONE;
            end
            default: begin
                result_d = half_q ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        endcase
        if (m.flush && state_q != IDLE) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end
    // state registers; reset clears everything including the visible result
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            half_q   <= half_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed plus randomized checks of mult_unit against a countdown/full-product model
module tb_mult_unit;
    logic CLK = 0;
    logic nRST;
    mult_unit_if #(.XLEN(32)) u();
    mult_unit #(.XLEN(32)) dut (.CLK(CLK), .nRST(nRST), .m(u));
    always #5 CLK = ~CLK;
    int vectors = 0;
    int miscompares = 0;
    int left = 0;
    int cyc = 0;
    int k = 0;
    bit go = 0;
    logic [31:0] m_res = 0;
    logic [31:0] m_pend = 0;
    logic        m_done = 0;
    function automatic logic [31:0] prod(logic [31:0] x, logic [31:0] y, logic sx, logic sy, logic h);
        logic [63:0] ex, ey, p;
        ex = {sx ? {32{x[31]}} : 32'b0, x};
        ey = {sy ? {32{y[31]}} : 32'b0, y};
        p = ex * ey;
        return h ? p[63:32] : p[31:0];
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // reference: an accepted op finishes 34 edges later unless flushed or reset
    always @(posedge CLK) begin
        cyc++;
        if (nRST) begin
            left = 0;
            m_res = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (left > 0) begin
                if (u.flush) left = 0;
                else begin
                    left--;
                    if (left == 0) begin
                        m_done = 1;
                        m_res = m_pend;
                    end
                end
            end else if (u.start && !u.flush) begin
                left = 34;
                m_pend = prod(u.a, u.b, u.signed_a, u.signed_b, u.half);
            end
        end
        go = 1;
    end
    // compare every cycle, away from the active edge
    always @(negedge CLK) if (go) begin
        check("busy", {31'b0, u.busy}, {31'b0, left > 0});
        check("done", {31'b0, u.done}, {31'b0, m_done});
        check("result", u.result, m_res);
    end
    task automatic launch(logic [31:0] x, logic [31:0] y, logic sx, logic sy, logic h);
        @(negedge CLK);
        u.start = 1; u.a = x; u.b = y; u.signed_a = sx; u.signed_b = sy; u.half = h;
        @(negedge CLK);
        u.start = 0; u.a = $urandom; u.b = $urandom;
        k = cyc;
    endtask
    task automatic wait_done();
        int n = 0;
        while (!u.done && n < 80) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", {31'b0, u.done}, 32'd1);
        check("latency", 32'(cyc - k), 32'd34);
    endtask
    function automatic logic [31:0] pick();
        int s = $urandom_range(0, 5);
        return s == 0 ? 32'h80000000 : s == 1 ? 32'hFFFFFFFF : s == 2 ? 32'h0 : $urandom;
    endfunction
    initial begin
        nRST = 1;
        u.start = 0; u.a = 0; u.b = 0; u.signed_a = 0; u.signed_b = 0; u.half = 0; u.flush = 0;
        check("model_mulh", prod(32'h80000000, 32'h80000000, 1, 1, 1), 32'h40000000);
        check("model_mulhsu", prod(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1), 32'hFFFFFFFF);
        repeat (2) @(negedge CLK);
        nRST = 0;
        check("rst_busy", {31'b0, u.busy}, 32'd0);
        check("rst_result", u.result, 32'd0);
        launch(7, 6, 0, 0, 0);
        check("busy_after_accept", {31'b0, u.busy}, 32'd1);
        wait_done();
        check("mul_7x6", u.result, 32'h2A);
        launch(32'h80000000, 32'h80000000, 1, 1, 1); wait_done();
        check("mulh_min", u.result, 32'h40000000);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1); wait_done();
        check("mulhsu", u.result, 32'hFFFFFFFF);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1); wait_done();
        check("mulhu", u.result, 32'hFFFFFFFE);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0); wait_done();
        check("mul_neg1", u.result, 32'h1);
        launch(3, 5, 0, 0, 0);
        repeat (4) @(negedge CLK);
        u.start = 1; u.a = 100; u.b = 100;
        @(negedge CLK);
        u.start = 0;
        wait_done();
        check("ignored_start", u.result, 32'd15);
        launch(9, 9, 0, 0, 0);
        repeat (9) @(negedge CLK);
        u.flush = 1;
        @(negedge CLK);
        u.flush = 0;
        check("flush_busy", {31'b0, u.busy}, 32'd0);
        check("flush_result", u.result, 32'd15);
        repeat (40) @(negedge CLK);
        check("flush_hold", u.result, 32'd15);
        launch(11, 13, 0, 0, 0);
        repeat (19) @(negedge CLK);
        nRST = 1;
        @(negedge CLK);
        nRST = 0;
        check("midrst_busy", {31'b0, u.busy}, 32'd0);
        check("midrst_result", u.result, 32'd0);
        launch(11, 13, 0, 0, 0); wait_done();
        check("after_rst", u.result, 32'd143);
        @(negedge CLK);
        u.start = 1; u.flush = 1;
        @(negedge CLK);
        u.start = 0; u.flush = 0;
        check("start_flush_busy", {31'b0, u.busy}, 32'd0);
        repeat (40) @(negedge CLK);
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            u.start = $urandom_range(0, 3) == 0;
            u.a = pick(); u.b = pick();
            u.signed_a = $urandom_range(0, 1) != 0;
            u.signed_b = $urandom_range(0, 1) != 0;
            u.half = $urandom_range(0, 1) != 0;
            u.flush = $urandom_range(0, 79) == 0;
            nRST = $urandom_range(0, 999) == 0;
        end
        @(negedge CLK);
        u.start = 0; u.flush = 0; nRST = 0;
        repeat (40) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
